// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encoding and FSM states.
// Optional rotate support is enabled by defining USR_ROTATE_EN.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ASR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ops that enter the SHIFT state when given a nonzero count.
  function automatic logic is_shift_op(input op_t op);
    case (op)
      OP_SHL, OP_SHR, OP_ASR: is_shift_op = 1'b1;
`ifdef USR_ROTATE_EN
      OP_ROL, OP_ROR:         is_shift_op = 1'b1;
`endif
      default:                is_shift_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit shifter used by universal_shift_reg.
// Rotate cases exist only when USR_ROTATE_EN is defined.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_t              op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_q  = {q[WIDTH-2:0], sin_l};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        next_q  = {sin_r, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
`ifdef USR_ROTATE_EN
      OP_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
`endif
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: LOAD/CLR/NOP in one cycle, multi-cycle shifts via an IDLE/SHIFT FSM.
// Define USR_ROTATE_EN to enable ROL/ROR; otherwise they are accepted as NOP.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly in IDLE, and cmd_valid is ignored while shifting.

  state_t           state, state_nxt;
  op_t              op_in, op_r;
  logic [CNT_W-1:0] remaining;
  logic             accept, start_shift;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign op_in       = op_t'(cmd_op);
  assign accept      = cmd_valid && cmd_ready;
  assign start_shift = accept && is_shift_op(op_in) && (cmd_cnt != '0);

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .op      (op_r),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .next_q  (step_q),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_shift) state_nxt = ST_SHIFT;
      ST_SHIFT: if (remaining <= CNT_W'(1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state == ST_SHIFT);
  end

  // Datapath: q/sout only move on shift edges, LOAD and CLR; sout untouched otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q         <= '0;
      sout      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      op_r      <= OP_NOP;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start_shift) begin
          op_r      <= op_in;
          remaining <= cmd_cnt;
        end else if (accept) begin
          done <= 1'b1;
          if (op_in == OP_LOAD)     q <= load_data;
          else if (op_in == OP_CLR) q <= '0;
        end
      end else begin
        q    <= step_q;
        sout <= step_bit;
        if (remaining != '0)          remaining <= remaining - CNT_W'(1);
        if (remaining <= CNT_W'(1))   done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed table-driven bench for universal_shift_reg (WIDTH=8, CNT_W=4).
// Expected values follow USR_ROTATE_EN when it is defined for the build.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] load_data;
  logic       sin_l, sin_r;
  logic [7:0] q;
  logic       sout, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .load_data (load_data),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    logic       exp_sout;
    int         exp_busy;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command from IDLE, then counts busy cycles until done (bounded).
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data,
                         input logic sl, input logic sr, output int busy_cnt, output logic seen);
    @(negedge clk);
    cmd_op = op; cmd_cnt = cnt; load_data = data; sin_l = sl; sin_r = sr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data,
                              input logic sl, input logic sr, input logic [7:0] eq,
                              input logic es, input int eb);
    vec_t v;
    v.op = op; v.cnt = cnt; v.data = data; v.sl = sl; v.sr = sr;
    v.exp_q = eq; v.exp_sout = es; v.exp_busy = eb;
    return v;
  endfunction

  initial begin
    int   bc;
    logic seen;
    logic [3:0] pat;
    logic rot_s;

    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 4'd0;
    load_data = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

    // Reset: two low cycles
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_sout", sout, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);

`ifdef USR_ROTATE_EN
    rot_s = 1'b1;
    tbl[5] = mk(3'd6, 4'd4, 8'h00, 1'b0, 1'b0, 8'hE1, 1'b1, 4);
    tbl[7] = mk(3'd5, 4'd3, 8'h00, 1'b0, 1'b0, 8'hB4, 1'b0, 3);
`else
    rot_s = 1'b0;
    tbl[5] = mk(3'd6, 4'd4, 8'h00, 1'b0, 1'b0, 8'h1E, 1'b0, 0);
    tbl[7] = mk(3'd5, 4'd3, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, 0);
`endif
    tbl[0]  = mk(3'd1, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 0);
    tbl[1]  = mk(3'd2, 4'd3,  8'h00, 1'b1, 1'b0, 8'h2F, 1'b1, 3);
    tbl[2]  = mk(3'd1, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 0);
    tbl[3]  = mk(3'd4, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE0, 1'b0, 2);
    tbl[4]  = mk(3'd1, 4'd0,  8'h1E, 1'b0, 1'b0, 8'h1E, 1'b0, 0);
    tbl[6]  = mk(3'd1, 4'd0,  8'h96, 1'b0, 1'b0, 8'h96, rot_s, 0);
    tbl[8]  = mk(3'd1, 4'd0,  8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 0);
    tbl[9]  = mk(3'd3, 4'd2,  8'h00, 1'b0, 1'b1, 8'hF0, 1'b1, 2);
    tbl[10] = mk(3'd2, 4'd0,  8'h00, 1'b1, 1'b0, 8'hF0, 1'b1, 0);
    tbl[11] = mk(3'd7, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    tbl[12] = mk(3'd0, 4'd5,  8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    tbl[13] = mk(3'd1, 4'd0,  8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 0);
    tbl[14] = mk(3'd3, 4'd15, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 15);
    tbl[15] = mk(3'd1, 4'd0,  8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 0);
    tbl[16] = mk(3'd4, 4'd8,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8);
    tbl[17] = mk(3'd6, 4'd0,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 0);

    for (int i = 0; i < NV; i++) begin
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].sl, tbl[i].sr, bc, seen);
      check($sformatf("v%0d_done_seen", i), seen, 1'b1);
      check($sformatf("v%0d_busy_cycles", i), bc, tbl[i].exp_busy);
      check($sformatf("v%0d_q", i), q, tbl[i].exp_q);
      check($sformatf("v%0d_sout", i), sout, tbl[i].exp_sout);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 1'b0);
    end

    // Serial input resampled on each shift edge: 1,0,1,1 -> 0x0B
    run_cmd(3'd1, 4'd0, 8'h00, 1'b0, 1'b0, bc, seen);
    pat = 4'b1101;
    @(negedge clk);
    cmd_op = 3'd2; cmd_cnt = 4'd4; cmd_valid = 1'b1; sin_l = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sin_l = pat[k];
    end
    @(negedge clk);
    check("serial_done", done, 1'b1);
    check("serial_q", q, 8'h0B);
    check("serial_sout", sout, 1'b0);

    // Back-to-back: CLR held during SHR 5 is taken in the done cycle
    @(negedge clk);
    cmd_op = 3'd1; load_data = 8'h0F; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 3'd3; cmd_cnt = 4'd5; sin_r = 1'b1;
    @(posedge clk);
    #1 cmd_op = 3'd7;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) begin
        bc++;
        check("b2b_ready_low", cmd_ready, 1'b0);
      end
    end
    check("b2b_done_seen", seen, 1'b1);
    check("b2b_busy_cycles", bc, 5);
    check("b2b_q_before_clr", q, 8'hF8);
    check("b2b_sout", sout, 1'b0);
    check("b2b_ready_done", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_clr_q", q, 8'h00);
    check("b2b_clr_done", done, 1'b1);
    check("b2b_clr_busy", busy, 1'b0);

    // Reset during SHL 8, asserted at the third shift edge
    run_cmd(3'd1, 4'd0, 8'hFF, 1'b0, 1'b0, bc, seen);
    @(negedge clk);
    cmd_op = 3'd2; cmd_cnt = 4'd8; sin_l = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("abort_q_mid", q, 8'hFC);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("abort_q", q, 8'h00);
    check("abort_sout", sout, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width; SHALL be at least 2.
REQ-002 Parameter CNT_W, default 4, shift-count width; maximum count is 2^CNT_W-1.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  operation: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 CLR.
REQ-008 cmd_cnt  input  CNT_W  number of single-bit shifts for ops 2-6.
REQ-009 load_data  input  WIDTH  parallel load value for LOAD.
REQ-010 sin_l  input  1  serial fill bit into q[0] on SHL.
REQ-011 sin_r  input  1  serial fill bit into q[WIDTH-1] on SHR.
REQ-012 q  output  WIDTH  register contents.
REQ-013 sout  output  1  registered copy of the bit most recently shifted out.
REQ-014 busy  output  1  high while in the SHIFT state.
REQ-015 done  output  1  one-cycle completion pulse per accepted command.

Function
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal (state == IDLE).
REQ-017 FSM states SHALL be IDLE and SHIFT only.
REQ-018 LOAD SHALL write q to load_data on the accept edge. CLR SHALL write q to 0 on the accept edge. NOP SHALL leave q unchanged. All three SHALL stay in IDLE, and done SHALL be high for the following cycle.
REQ-019 For a shift op with cmd_cnt = 0, the block SHALL behave as NOP.
REQ-020 For a shift op with cmd_cnt = N >= 1:
- the accept edge SHALL latch op and remaining = N and enter SHIFT;
- each subsequent edge SHALL perform one shift and decrement remaining;
- the edge performing the Nth shift SHALL return to IDLE;
- done SHALL be high for the next cycle;
- total latency is accept + N edges.
REQ-021 SHL: q <= {q[WIDTH-2:0], sin_l}; sout <= old q[WIDTH-1].
REQ-022 SHR: q <= {sin_r, q[WIDTH-1:1]}; sout <= old q[0].
REQ-023 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sout <= old q[0].
REQ-024 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}. ROR: q <= {q[0], q[WIDTH-1:1]}. In both cases sout SHALL take the bit that wrapped.
REQ-025 sin_l and sin_r SHALL be sampled on every shift edge, so a new serial bit is taken each cycle.
REQ-026 sout SHALL hold its value outside shift edges. LOAD, CLR and NOP SHALL NOT change sout.
REQ-027 While in SHIFT, cmd_valid SHALL be ignored; the pending command SHALL be accepted in the first IDLE cycle, which may be the done cycle (back-to-back).
REQ-028 The remaining-count register SHALL be CNT_W bits wide and SHALL never underflow.

Reset
REQ-029 When rstn is low on an edge:
- q = 0, sout = 0, done = 0, remaining = 0;
- state = IDLE, so busy = 0 and cmd_ready = 1;
- this SHALL apply in any state, including mid-SHIFT, with no done pulse for the aborted command.

Configuration
REQ-030 Macro USR_ROTATE_EN defined: ROL and ROR SHALL behave per REQ-024.
REQ-031 Macro USR_ROTATE_EN undefined: ROL and ROR SHALL be accepted as NOP (q unchanged, no SHIFT entry, done one cycle after accept), and no rotate logic SHALL be synthesised.

Structure
REQ-032 Package usr_pkg SHALL hold the 3-bit operation enum (OP_NOP through OP_CLR) and the FSM state typedef.
REQ-033 Sub-module usr_shift_step SHALL be a combinational single-step shifter: inputs q, op, sin_l, sin_r; outputs next_q and out_bit. The FSM and registers SHALL stay in the top level.

Verification (WIDTH=8, CNT_W=4)
REQ-034 Reset: drive rstn low for 2 cycles -> q=0x00, sout=0, done=0, busy=0, cmd_ready=1.
REQ-035 LOAD 0xA5, then SHL cnt=3 with sin_l=1 -> busy for 3 cycles, q=0x2F, sout=1, done high for exactly 1 cycle.
REQ-036 LOAD 0x81, then ASR cnt=2 -> q=0xE0, sout=0.
REQ-037 LOAD 0x1E, then ROR cnt=4 -> with macro: q=0xE1 after 4 shifts; without macro: q=0x1E and done on the cycle after accept.
REQ-038 LOAD 0x0F, then SHR cnt=5 with cmd_valid held high carrying CLR -> CLR not accepted until the done cycle, q=0x00 one edge later; separately, SHL cnt=0 -> q unchanged and done pulses.
REQ-039 LOAD 0xFF, then SHL cnt=8; assert rstn low at the 3rd shift edge -> q=0x00, state IDLE, no done pulse.
